// File: rtl/rpn_stack_controller_if.sv
// Token/result bus between the UART parser, the RPN stack controller and the TX formatter.
interface rpn_stack_controller_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic             num_ready;
  logic [WIDTH-1:0] num;
  logic             op_ready;
  logic [3:0]       op;
  logic             res_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             busy;
  logic [DW-1:0]    depth;

  modport master (
    output num_ready, num, op_ready, op, res_ready,
    input  res_valid, res_data, res_err, busy, depth
  );

  modport slave (
    input  num_ready, num, op_ready, op, res_ready,
    output res_valid, res_data, res_err, busy, depth
  );
endinterface

// File: rtl/rpn_stack_controller.sv
// RPN calculator sequencer: operand stack, small ALU with iterative divide, result hand-off.
module rpn_stack_controller #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rpn_stack_controller_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] D_ONE      = DW'(1);
  localparam logic [DW-1:0] D_TWO      = DW'(2);
  localparam logic [CW-1:0] DIV_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [3:0]    OP_EOL     = 4'hF;
  localparam logic [1:0]    OP_DIV     = 2'd3;

  typedef enum logic [2:0] {IDLE, EXEC, DIV, WB, EMIT} state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [DW-1:0]    depth_q;
  logic             err;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    div_cnt;
  logic [WIDTH-1:0] res_data_q;
  logic             res_err_q;

  logic             in_idle;
  logic             op_arith;
  logic             op_eol;
  logic             push_en;
  logic             op_go;
  logic             eol_go;
  logic             wb_en;
  logic [PW-1:0]    push_idx;
  logic [PW-1:0]    nos_idx;
  logic [PW-1:0]    tos_idx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;

  assign in_idle  = (state == IDLE);
  assign op_arith = (bus.op[3:2] == 2'b00);
  assign op_eol   = (bus.op == OP_EOL);
  assign push_en  = in_idle && bus.num_ready && (depth_q < DEPTH_FULL);
  assign op_go    = in_idle && !bus.num_ready && bus.op_ready && op_arith && (depth_q >= D_TWO);
  assign eol_go   = in_idle && !bus.num_ready && bus.op_ready && op_eol;
  assign wb_en    = (state == WB);
  assign push_idx = depth_q[PW-1:0];
  assign nos_idx  = PW'(depth_q - D_TWO);
  assign tos_idx  = PW'(depth_q - D_ONE);

  assign div_shift    = {rem, quo[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, b};
  assign div_ge       = !div_diff[WIDTH];
  assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_next = {quo[WIDTH-2:0], div_ge};

  // State register; reset aborts any operation in flight, including a pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a number on the same cycle as an operator suppresses the operator.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (op_go) begin
          next_state = EXEC;
        end else if (eol_go) begin
          next_state = EMIT;
        end
      end
      EXEC: begin
        if (op_q == OP_DIV && b != '0) begin
          next_state = DIV;
        end else begin
          next_state = WB;
        end
      end
      DIV: begin
        if (div_cnt == DIV_LAST) begin
          next_state = WB;
        end
      end
      WB: begin
        next_state = IDLE;
      end
      EMIT: begin
        if (bus.res_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Occupancy, sticky error flag and the latched end-of-line result; the handshake clears err last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_q    <= '0;
      err        <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      if (!in_idle && (bus.num_ready || bus.op_ready)) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.num_ready) begin
            if (depth_q < DEPTH_FULL) begin
              depth_q <= depth_q + D_ONE;
            end else begin
              err <= 1'b1;
            end
            if (bus.op_ready) begin
              err <= 1'b1;
            end
          end else if (bus.op_ready) begin
            if (op_arith) begin
              if (depth_q < D_TWO) begin
                err <= 1'b1;
              end
            end else if (op_eol) begin
              if (depth_q == D_ONE && !err) begin
                res_data_q <= stack[0];
                res_err_q  <= 1'b0;
              end else begin
                res_data_q <= '0;
                res_err_q  <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (op_q == OP_DIV && b == '0) begin
            err <= 1'b1;
          end
        end
        WB: begin
          depth_q <= depth_q - D_ONE;
        end
        EMIT: begin
          if (bus.res_ready) begin
            depth_q <= '0;
            err     <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ALU operands and restoring divider; these are only meaningful between EXEC and WB, so no reset.
  always_ff @(posedge clk) begin
    if (op_go) begin
      a    <= stack[nos_idx];
      b    <= stack[tos_idx];
      op_q <= bus.op[1:0];
    end
    case (state)
      EXEC: begin
        case (op_q)
          2'd0:    r <= a + b;
          2'd1:    r <= a - b;
          2'd2:    r <= a * b;
          default: r <= '0;
        endcase
        rem     <= '0;
        quo     <= a;
        div_cnt <= '0;
      end
      DIV: begin
        rem     <= div_rem_next;
        quo     <= div_quo_next;
        div_cnt <= div_cnt + C_ONE;
        if (div_cnt == DIV_LAST) begin
          r <= div_quo_next;
        end
      end
      default: begin
      end
    endcase
  end

  // Stack storage is deliberately not reset; only the occupancy count is.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack[push_idx] <= bus.num;
    end else if (wb_en) begin
      stack[nos_idx] <= r;
    end
  end

  // Outputs decoded from state; the result bus reads zero outside EMIT.
  always_comb begin
    bus.res_valid = (state == EMIT);
    bus.res_data  = (state == EMIT) ? res_data_q : '0;
    bus.res_err   = (state == EMIT) && res_err_q;
    bus.busy      = (state != IDLE);
    bus.depth     = depth_q;
  end

endmodule

// File: doc/rpn_stack_controller.md
# rpn_stack_controller

Sequencing controller between the UART token parser and the UART result transmitter in the RPN calculator. Consumes number tokens (`num_ready`/`num`) and operator tokens (`op_ready`/`op`), maintains the operand stack, drives the internal ALU (add/sub/mul, iterative divide) and, on end-of-line, hands the final result or an error indication to the TX formatter over a valid/ready handshake.

## Interface
- `DEPTH`, 8: operand stack entries (power of two, ≥2)
- `WIDTH`, 16: operand/result width in bits
- `clk`  in  1  system clock (125 MHz)
- `rst_n`  in  1  synchronous reset, active-low
- `num_ready`  in  1  one-cycle pulse: `num` holds a completed number token
- `num`  in  WIDTH  unsigned number token
- `op_ready`  in  1  one-cycle pulse: `op` holds an operator token
- `op`  in  4  0=add, 1=sub, 2=mul, 3=div, 4'hF=end-of-line; all other codes invalid
- `res_ready`  in  1  TX formatter accepts result
- `res_valid`  out  1  result/error available
- `res_data`  out  WIDTH  final result; 0 when `res_err`=1
- `res_err`  out  1  line evaluated with an error
- `busy`  out  1  high whenever state ≠ IDLE
- `depth`  out  $clog2(DEPTH)+1  current stack occupancy

Reset is synchronous and active-low on `rst_n`; single clock domain `clk`.

## Operation
- States: IDLE, EXEC, DIV, WB, EMIT.
- IDLE, `num_ready`: if depth<DEPTH, write `num` to stack[depth], depth+1; else set sticky `err`, push dropped. State stays IDLE.
- IDLE, `op_ready` with op 0–3: if depth<2, set `err`, stay IDLE; else latch a=stack[depth-2], b=stack[depth-1], go EXEC.
- IDLE, `op_ready` with invalid code: set `err`, stay IDLE.
- EXEC: add/sub/mul compute r (low WIDTH bits, modulo 2^WIDTH, unsigned), go WB. Div: if b==0, set `err`, r=0, go WB; else go DIV.
- DIV: restoring unsigned divide, one quotient bit per cycle, WIDTH cycles; quotient truncated; then WB.
- WB: stack[depth-2]=r, depth-1, go IDLE.
- IDLE, `op_ready` with 4'hF: go EMIT. `res_data`=stack[0] and `res_err`=0 iff depth==1 and `err`==0; otherwise `res_data`=0, `res_err`=1.
- EMIT: `res_valid` held high, `res_data`/`res_err` stable until `res_ready`. On the handshake cycle: depth←0, `err`←0, go IDLE, `res_valid` low next cycle.
- `num_ready` and `op_ready` in the same cycle: number processed, operator dropped, `err` set.
- Any token arriving while state ≠ IDLE: dropped, `err` set (reported on the next EOL; in EMIT the flag is cleared by the handshake, so it is lost by design).
- Stack contents are not cleared by reset or EMIT; only depth is zeroed.

## Timing
- Reset values: `res_valid`=0, `res_data`=0, `res_err`=0, `busy`=0, `depth`=0, state IDLE, `err`=0. Reset mid-operation (DIV, EMIT) aborts immediately; no result emitted.
- Push: token at edge T → `depth` updated after edge T.
- add/sub/mul: op accepted at edge T → EXEC after T, WB after T+1, IDLE with result on top and depth-1 after T+2. `busy` high for 2 cycles.
- div: EXEC (1) + DIV (WIDTH) + WB (1) → IDLE after T+WIDTH+2 (18 cycles at WIDTH=16).
- EOL: `res_valid` rises the cycle after the EOL edge; minimum valid time 1 cycle (`res_ready` already high).
- Token spacing at 115200 baud (~10850 cycles/char) guarantees busy never overlaps legitimate tokens.

## Test plan
- Tokens 12,12,+,3,*,2,/,EOL with `res_ready`=1 → `res_valid` pulse with `res_data`=36, `res_err`=0, then depth=0.
- 5,7,−,EOL → `res_data`=0xFFFE (wrap), `res_err`=0; 300,300,*,EOL → `res_data`=0x5F90 (90000 mod 65536).
- 9,0,/,EOL → `res_err`=1, `res_data`=0; next line 100,7,/,EOL → 14, `res_err`=0 (err cleared); div result appears exactly 18 cycles after op pulse.
- Stack errors: + with depth 1 → EOL gives `res_err`=1; 9 pushes (DEPTH=8) → overflow error; 1,2,EOL (depth 2) → `res_err`=1.
- Backpressure: hold `res_ready`=0 for 50 cycles after EOL → `res_valid`, `res_data` stable, `busy`=1; number pulsed meanwhile is dropped; release → single handshake, IDLE.
- Simultaneous `num_ready`+`op_ready`, and `rst_n`=0 during DIV → respectively push only + error on EOL; all outputs at reset values next cycle, no `res_valid`.
